// File: rtl/pma_lookup_unit.sv
// Two-stage PMA lookup: physical address -> cacheable / non-idempotent / executable bits.
// Optional saturating performance counters are compiled in with PMA_LOOKUP_PERF_EN.

package config_pkg;
  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                 PLEN;
    int unsigned                 NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
    int unsigned                 NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
    int unsigned                 NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    PLEN:                  32'd56,
    NrNonIdempotentRules:  32'd0,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0,
    NrExecuteRegionRules:  32'd0,
    ExecuteRegionAddrBase: '0,
    ExecuteRegionLength:   '0,
    NrCachedRegionRules:   32'd0,
    CachedRegionAddrBase:  '0,
    CachedRegionLength:    '0
  };
endpackage

module pma_lookup_unit #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
  parameter int unsigned           TidWidth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [CVA6Cfg.PLEN-1:0] req_addr_i,
  input  logic                    req_fetch_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [TidWidth-1:0]     resp_tid_o,
  output logic                    resp_cacheable_o,
  output logic                    resp_nonidem_o,
  output logic                    resp_exec_o,
  output logic                    resp_exec_fault_o,
  output logic [31:0]             perf_lookups_o,
  output logic [31:0]             perf_exec_faults_o
);

  localparam int unsigned NrMaxRules = config_pkg::NrMaxRules;
  localparam bit          ExecAll    = (CVA6Cfg.NrExecuteRegionRules == 0);

  // 65-bit limit keeps a region that ends exactly at 2^64 from wrapping to zero.
  function automatic logic range_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] len);
    logic [64:0] limit;
    limit = {1'b0, base} + {1'b0, len};
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  logic [63:0]           addr_ext;
  logic [NrMaxRules-1:0] nonidem_hit;
  logic [NrMaxRules-1:0] exec_hit;
  logic [NrMaxRules-1:0] cached_hit;

  assign addr_ext = 64'(req_addr_i);

  for (genvar gi = 0; gi < NrMaxRules; gi++) begin : g_rule
    if (gi < int'(CVA6Cfg.NrNonIdempotentRules)) begin : g_ni_on
      assign nonidem_hit[gi] = range_hit(addr_ext, CVA6Cfg.NonIdempotentAddrBase[gi],
                                         CVA6Cfg.NonIdempotentLength[gi]);
    end else begin : g_ni_off
      assign nonidem_hit[gi] = 1'b0;
    end

    if (gi < int'(CVA6Cfg.NrExecuteRegionRules)) begin : g_ex_on
      assign exec_hit[gi] = range_hit(addr_ext, CVA6Cfg.ExecuteRegionAddrBase[gi],
                                      CVA6Cfg.ExecuteRegionLength[gi]);
    end else begin : g_ex_off
      assign exec_hit[gi] = 1'b0;
    end

    if (gi < int'(CVA6Cfg.NrCachedRegionRules)) begin : g_ca_on
      assign cached_hit[gi] = range_hit(addr_ext, CVA6Cfg.CachedRegionAddrBase[gi],
                                        CVA6Cfg.CachedRegionLength[gi]);
    end else begin : g_ca_off
      assign cached_hit[gi] = 1'b0;
    end
  end

  logic                  s1_valid_q,   s1_valid_d;
  logic [NrMaxRules-1:0] s1_nonidem_q, s1_nonidem_d;
  logic [NrMaxRules-1:0] s1_exec_q,    s1_exec_d;
  logic [NrMaxRules-1:0] s1_cached_q,  s1_cached_d;
  logic                  s1_fetch_q,   s1_fetch_d;
  logic [TidWidth-1:0]   s1_tid_q,     s1_tid_d;

  logic                  s2_valid_q,     s2_valid_d;
  logic                  s2_cacheable_q, s2_cacheable_d;
  logic                  s2_nonidem_q,   s2_nonidem_d;
  logic                  s2_exec_q,      s2_exec_d;
  logic                  s2_fault_q,     s2_fault_d;
  logic [TidWidth-1:0]   s2_tid_q,       s2_tid_d;

  logic s2_load;
  logic s1_load;
  logic req_accept;
  logic resp_fire;
  logic s2_exec_eval;

  assign s2_load      = !s2_valid_q || resp_ready_i;
  assign s1_load      = !s1_valid_q || s2_load;
  assign req_ready_o  = s1_load && !flush_i && rst_ni;
  assign req_accept   = req_valid_i && req_ready_o;
  assign resp_fire    = s2_valid_q && resp_ready_i;
  assign s2_exec_eval = ExecAll ? 1'b1 : |s1_exec_q;

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_nonidem_d   = s1_nonidem_q;
    s1_exec_d      = s1_exec_q;
    s1_cached_d    = s1_cached_q;
    s1_fetch_d     = s1_fetch_q;
    s1_tid_d       = s1_tid_q;
    s2_valid_d     = s2_valid_q;
    s2_cacheable_d = s2_cacheable_q;
    s2_nonidem_d   = s2_nonidem_q;
    s2_exec_d      = s2_exec_q;
    s2_fault_d     = s2_fault_q;
    s2_tid_d       = s2_tid_q;

    if (s1_load) s1_valid_d = req_accept;
    if (req_accept) begin
      s1_nonidem_d = nonidem_hit;
      s1_exec_d    = exec_hit;
      s1_cached_d  = cached_hit;
      s1_fetch_d   = req_fetch_i;
      s1_tid_d     = req_tid_i;
    end

    // Output registers only change when a real entry moves in, so a stalled response holds.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_cacheable_d = |s1_cached_q;
        s2_nonidem_d   = |s1_nonidem_q;
        s2_exec_d      = s2_exec_eval;
        s2_fault_d     = s1_fetch_q && !s2_exec_eval;
        s2_tid_d       = s1_tid_q;
      end
    end

    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q     <= 1'b0;
      s1_nonidem_q   <= '0;
      s1_exec_q      <= '0;
      s1_cached_q    <= '0;
      s1_fetch_q     <= 1'b0;
      s1_tid_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_cacheable_q <= 1'b0;
      s2_nonidem_q   <= 1'b0;
      s2_exec_q      <= 1'b0;
      s2_fault_q     <= 1'b0;
      s2_tid_q       <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_nonidem_q   <= s1_nonidem_d;
      s1_exec_q      <= s1_exec_d;
      s1_cached_q    <= s1_cached_d;
      s1_fetch_q     <= s1_fetch_d;
      s1_tid_q       <= s1_tid_d;
      s2_valid_q     <= s2_valid_d;
      s2_cacheable_q <= s2_cacheable_d;
      s2_nonidem_q   <= s2_nonidem_d;
      s2_exec_q      <= s2_exec_d;
      s2_fault_q     <= s2_fault_d;
      s2_tid_q       <= s2_tid_d;
    end
  end

  assign resp_valid_o      = s2_valid_q;
  assign resp_tid_o        = s2_tid_q;
  assign resp_cacheable_o  = s2_cacheable_q;
  assign resp_nonidem_o    = s2_nonidem_q;
  assign resp_exec_o       = s2_exec_q;
  assign resp_exec_fault_o = s2_fault_q;

`ifdef PMA_LOOKUP_PERF_EN
  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_exec_faults_q, perf_exec_faults_d;

  always_comb begin
    perf_lookups_d     = perf_lookups_q;
    perf_exec_faults_d = perf_exec_faults_q;
    if (req_accept && (perf_lookups_q != 32'hFFFF_FFFF))
      perf_lookups_d = perf_lookups_q + 32'd1;
    if (resp_fire && s2_fault_q && (perf_exec_faults_q != 32'hFFFF_FFFF))
      perf_exec_faults_d = perf_exec_faults_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_lookups_q     <= '0;
      perf_exec_faults_q <= '0;
    end else begin
      perf_lookups_q     <= perf_lookups_d;
      perf_exec_faults_q <= perf_exec_faults_d;
    end
  end

  assign perf_lookups_o     = perf_lookups_q;
  assign perf_exec_faults_o = perf_exec_faults_q;
`else
  logic unused_fire;
  assign unused_fire        = resp_fire;
  assign perf_lookups_o     = '0;
  assign perf_exec_faults_o = '0;
`endif

endmodule

// File: tb/tb_pma_lookup_unit.sv
// Bench for pma_lookup_unit: region-rule model plus an in-order occupancy scoreboard,
// checked every cycle against two DUTs (with and without execute rules).

module tb_pma_lookup_unit;

  localparam int unsigned TW = 4;

  function automatic config_pkg::cva6_cfg_t make_cfg(input bit exec_rules);
    config_pkg::cva6_cfg_t c;
    c = config_pkg::cva6_cfg_empty;
    c.NrCachedRegionRules      = 2;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    c.CachedRegionAddrBase[1]  = 64'h0;          // zero length: must never match
    c.CachedRegionLength[1]    = 64'h0;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h8000_0000;
    c.NonIdempotentAddrBase[1] = 64'hC000_0000;  // beyond the active count: ignored
    c.NonIdempotentLength[1]   = 64'h1000_0000;
    c.ExecuteRegionAddrBase[0] = 64'h1_0000;
    c.ExecuteRegionLength[0]   = 64'h1_0000;
    c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
    c.ExecuteRegionLength[1]   = 64'h4000_0000;
    c.NrExecuteRegionRules     = exec_rules ? 32'd2 : 32'd0;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t CFG_A = make_cfg(1'b1);
  localparam config_pkg::cva6_cfg_t CFG_B = make_cfg(1'b0);
  localparam int unsigned PL = CFG_A.PLEN;

  logic clk, rst_n, flush, req_valid, req_fetch, resp_ready;
  logic [PL-1:0] req_addr;
  logic [TW-1:0] req_tid;

  logic          req_ready_a, resp_valid_a, ca_a, ni_a, ex_a, fa_a;
  logic [TW-1:0] tid_a;
  logic [31:0]   pl_a, pf_a;
  logic          req_ready_b, resp_valid_b, ca_b, ni_b, ex_b, fa_b;
  logic [TW-1:0] tid_b;
  logic [31:0]   pl_b, pf_b;

  pma_lookup_unit #(.CVA6Cfg(CFG_A), .TidWidth(TW)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready_a), .req_addr_i(req_addr),
    .req_fetch_i(req_fetch), .req_tid_i(req_tid),
    .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready), .resp_tid_o(tid_a),
    .resp_cacheable_o(ca_a), .resp_nonidem_o(ni_a), .resp_exec_o(ex_a),
    .resp_exec_fault_o(fa_a), .perf_lookups_o(pl_a), .perf_exec_faults_o(pf_a)
  );

  pma_lookup_unit #(.CVA6Cfg(CFG_B), .TidWidth(TW)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready_b), .req_addr_i(req_addr),
    .req_fetch_i(req_fetch), .req_tid_i(req_tid),
    .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready), .resp_tid_o(tid_b),
    .resp_cacheable_o(ca_b), .resp_nonidem_o(ni_b), .resp_exec_o(ex_b),
    .resp_exec_fault_o(fa_b), .perf_lookups_o(pl_b), .perf_exec_faults_o(pf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Region membership from the rule lists: addr - base < len, only for the active rules.
  function automatic bit in_region(input logic [63:0] a, input int unsigned n,
                                   input logic [15:0][63:0] base,
                                   input logic [15:0][63:0] len);
    for (int k = 0; k < int'(n) && k < 16; k++)
      if (len[k] != 0 && a >= base[k] && (a - base[k]) < len[k]) return 1'b1;
    return 1'b0;
  endfunction

  // Returns {cacheable, nonidem, exec, exec_fault}.
  function automatic logic [3:0] model_attr(input config_pkg::cva6_cfg_t c,
                                            input logic [PL-1:0] addr, input bit fetch);
    logic [63:0] a;
    bit ca, ni, ex;
    a  = 64'(addr);
    ca = in_region(a, c.NrCachedRegionRules, c.CachedRegionAddrBase, c.CachedRegionLength);
    ni = in_region(a, c.NrNonIdempotentRules, c.NonIdempotentAddrBase, c.NonIdempotentLength);
    ex = (c.NrExecuteRegionRules == 0) ? 1'b1 :
         in_region(a, c.NrExecuteRegionRules, c.ExecuteRegionAddrBase, c.ExecuteRegionLength);
    return {ca, ni, ex, fetch && !ex};
  endfunction

  typedef struct {
    logic [TW-1:0] tid;
    logic [PL-1:0] addr;
    bit            fetch;
    int            acc_cyc;
    bit            has_lit;
    logic [3:0]    lit;
  } ent_t;

  ent_t q[$];
  bit   rst_prev_low = 1'b1;
  bit   drv_lit_en   = 1'b0;
  logic [3:0] drv_lit = '0;
  logic [31:0] m_lookups = '0;
  logic [31:0] m_faults  = '0;

  // Per-cycle compare: an entry accepted at cycle t is visible from cycle t+2 once it is the oldest.
  always @(negedge clk) begin
    bit exp_v, exp_ready, hs;
    logic [3:0] ea, eb;
    ent_t e;
    exp_v = rst_n && (q.size() > 0) && (q[0].acc_cyc + 2 <= cyc);

    if (rst_prev_low) begin
      chk("reset_outs_a", {resp_valid_a, tid_a, ca_a, ni_a, ex_a, fa_a}, 0);
      chk("reset_outs_b", {resp_valid_b, tid_b, ca_b, ni_b, ex_b, fa_b}, 0);
    end else if (rst_n) begin
      chk("resp_valid_a", resp_valid_a, exp_v);
      chk("resp_valid_b", resp_valid_b, exp_v);
      if (exp_v) begin
        ea = model_attr(CFG_A, q[0].addr, q[0].fetch);
        eb = model_attr(CFG_B, q[0].addr, q[0].fetch);
        chk("resp_tid_a", tid_a, q[0].tid);
        chk("resp_attr_a", {ca_a, ni_a, ex_a, fa_a}, ea);
        chk("resp_tid_b", tid_b, q[0].tid);
        chk("resp_attr_b", {ca_b, ni_b, ex_b, fa_b}, eb);
        if (q[0].has_lit) chk("resp_literal_a", {ca_a, ni_a, ex_a, fa_a}, q[0].lit);
      end
    end

    exp_ready = rst_n && !flush && (q.size() < 2 || (exp_v && resp_ready));
    chk("req_ready_a", req_ready_a, exp_ready);
    chk("req_ready_b", req_ready_b, exp_ready);

`ifdef PMA_LOOKUP_PERF_EN
    chk("perf_lookups", pl_a, m_lookups);
    chk("perf_exec_faults", pf_a, m_faults);
`else
    chk("perf_tied_off", {pl_a, pf_a, pl_b, pf_b}, 0);
`endif

    if (!rst_n) begin
      q.delete();
      m_lookups = '0;
      m_faults  = '0;
    end else begin
      hs = exp_v && resp_ready;
      if (hs) begin
        $display("resp tid=%0d addr=0x%0h attrs(ca,ni,ex,fault)=%b cycle=%0d",
                 q[0].tid, q[0].addr, {ca_a, ni_a, ex_a, fa_a}, cyc);
        if (model_attr(CFG_A, q[0].addr, q[0].fetch) & 4'b0001)
          if (m_faults != 32'hFFFF_FFFF) m_faults = m_faults + 1;
        void'(q.pop_front());
      end
      if (req_valid && exp_ready) begin
        e.tid = req_tid; e.addr = req_addr; e.fetch = req_fetch; e.acc_cyc = cyc;
        e.has_lit = drv_lit_en; e.lit = drv_lit;
        q.push_back(e);
        if (m_lookups != 32'hFFFF_FFFF) m_lookups = m_lookups + 1;
      end
      if (flush) q.delete();
    end
    rst_prev_low = !rst_n;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [PL-1:0] addr, input bit fetch, input logic [TW-1:0] tid,
                      input bit lit_en, input logic [3:0] lit);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_fetch = fetch; req_tid = tid;
    drv_lit_en = lit_en; drv_lit = lit;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready_a;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0; drv_lit_en = 1'b0;
    chk("accept_within_budget", ok, 1);
  endtask

  typedef struct {
    logic [PL-1:0] addr;
    bit            fetch;
    logic [TW-1:0] tid;
    logic [3:0]    lit;   // {cacheable, nonidem, exec, fault}
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{56'h8000_0000, 1'b1, 4'd1, 4'b1010};
    vecs[1] = '{56'hBFFF_FFFF, 1'b1, 4'd2, 4'b1010};
    vecs[2] = '{56'hC000_0000, 1'b1, 4'd3, 4'b0001};
    vecs[3] = '{56'h7FFF_FFFF, 1'b0, 4'd4, 4'b0100};
    vecs[4] = '{56'h1_FFFF,    1'b1, 4'd5, 4'b0110};
    vecs[5] = '{56'h2_0000,    1'b1, 4'd6, 4'b0101};
    vecs[6] = '{56'h0,         1'b1, 4'd7, 4'b0101};
    vecs[7] = '{56'hC000_0800, 1'b0, 4'd8, 4'b0000};
    vecs[8] = '{56'h1_0000,    1'b1, 4'd9, 4'b0110};

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_fetch = 1'b0;
    req_addr = '0; req_tid = '0; resp_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);

`ifdef PMA_LOOKUP_PERF_EN
    @(posedge clk);
    #2;
    dut_a.perf_lookups_q     = 32'hFFFF_FFFE;
    dut_a.perf_exec_faults_q = 32'hFFFF_FFFE;
    m_lookups = 32'hFFFF_FFFE;
    m_faults  = 32'hFFFF_FFFE;
    idle(1);
    for (int i = 0; i < 3; i++) send(56'hC000_0000, 1'b1, 4'(12 + i), 1'b1, 4'b0001);
    idle(5);
    chk("perf_faults_saturated", pf_a, 32'hFFFF_FFFF);
`endif

    // Isolated directed vectors: boundaries, edge regions, ignored and zero-length rules.
    foreach (vecs[i]) begin
      send(vecs[i].addr, vecs[i].fetch, vecs[i].tid, 1'b1, vecs[i].lit);
      idle(3);
    end

    // Back-to-back at full throughput.
    for (int i = 1; i <= 3; i++) send(56'h8000_1000 + 56'(i), 1'b1, 4'(i), 1'b0, 4'b0);
    idle(4);

    // Same sequence against a stalled consumer.
    resp_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 3; i++) send(56'h1_8000 + 56'(i), 1'b1, 4'(i), 1'b0, 4'b0);
      end
      begin
        idle(6);
        resp_ready = 1'b1;
      end
    join
    idle(5);

    // Flush with two held entries and a new request on the flush cycle.
    resp_ready = 1'b0;
    send(56'h9000_0000, 1'b1, 4'd5, 1'b0, 4'b0);
    send(56'hC000_0000, 1'b1, 4'd6, 1'b0, 4'b0);
    req_valid = 1'b1; req_addr = 56'h1_0004; req_fetch = 1'b1; req_tid = 4'd7;
    flush = 1'b1;
    idle(1);
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    idle(5);

    // Reset pulse while entries are in flight.
    send(56'h8000_0040, 1'b1, 4'd10, 1'b0, 4'b0);
    send(56'hC000_0040, 1'b1, 4'd11, 1'b0, 4'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(5);

    // Faulting fetches after reset, interleaved with a stall.
    for (int i = 0; i < 3; i++) send(56'hC000_0100, 1'b1, 4'(12 + i), 1'b0, 4'b0);
    resp_ready = 1'b0;
    idle(3);
    resp_ready = 1'b1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
